// File: rtl/pipelined_processor_pkg.sv
// Shared types and constants for the 5-stage RV32I subset pipeline.
// Latency: n/a (types only); the built-in program lives here as a helper function.
// Backpressure: none; the pipeline never stalls.
package pipelined_processor_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef struct packed {
        logic [31:0] insn;
    } if_id_t;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_wb_t;

    // Built-in program loaded into imem while reset is asserted.
    function automatic logic [31:0] program_word(input logic [5:0] idx);
        case (idx)
            6'd0:    return 32'h0050_0093; // addi x1,x0,5
            6'd1:    return 32'h00A0_0113; // addi x2,x0,10
            6'd5:    return 32'h0020_81B3; // add  x3,x1,x2
            6'd6:    return 32'h4011_0233; // sub  x4,x2,x1
            6'd7:    return 32'h0020_F2B3; // and  x5,x1,x2
            6'd8:    return 32'h0020_E333; // or   x6,x1,x2
            6'd9:    return 32'h0030_2023; // sw   x3,0(x0)
            6'd10:   return 32'h0000_2383; // lw   x7,0(x0)
            6'd14:   return 32'h0013_8513; // addi x10,x7,1
            default: return NOP_INSN;
        endcase
    endfunction

endpackage

// File: rtl/pipelined_processor_regfile.sv
// 32x32 register file, two combinational read ports, one write port; x0 reads 0.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none. Macro RF_BYPASS_EN forwards the same-cycle write data to reads.
module pp_regfile (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ra1_i,
    input  logic [4:0]        ra2_i,
    output logic [31:0]       rd1_o,
    output logic [31:0]       rd2_o,
    input  logic              we_i,
    input  logic [4:0]        wa_i,
    input  logic [31:0]       wd_i,
    output logic [31:0][31:0] regs_o
);

    logic [31:0][31:0] regs_q;

    // Register write; x0 is never written so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

`ifdef RF_BYPASS_EN
    // A read of the register being written this cycle sees the new value.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 :
                   (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 :
                   (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
`else
    // A read of the register being written this cycle sees the old value.
    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];
`endif

    assign regs_o = regs_q;

endmodule

// File: rtl/pipelined_processor.sv
// 5-stage in-order RV32I subset (ADD/SUB/AND/OR/ADDI/LW/SW), no hazards handled, PC+4 only.
// Latency: fetch on edge k+1, store on edge k+4, register write on edge k+5.
// Backpressure: none; never stalls. RF_BYPASS_EN selects register-file write bypass.
module pipelined_processor
    import pipelined_processor_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] debug_reg_x0,
    output logic [31:0] debug_reg_x1,
    output logic [31:0] debug_reg_x2,
    output logic [31:0] debug_reg_x3,
    output logic [31:0] debug_reg_x4,
    output logic [31:0] debug_reg_x5,
    output logic [31:0] debug_reg_x6,
    output logic [31:0] debug_reg_x7,
    output logic [31:0] debug_reg_x10,
    output logic [31:0] debug_data_mem_0
);

    // rst_n is active-high despite its name.
    logic rst;
    assign rst = rst_n;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    id_ex_t      id_ex_q, id_ex_d;
    ex_mem_t     ex_mem_q, ex_mem_d;
    mem_wb_t     mem_wb_q, mem_wb_d;

    logic [31:0]       rf_rd1, rf_rd2;
    logic [31:0][31:0] rf_regs;

    // IF: fetch wraps every 256 bytes.
    assign pc_d         = pc_q + 32'd4;
    assign if_id_d.insn = imem[pc_q[7:2]];

    // ID: instruction fields.
    logic [6:0] id_opcode, id_funct7;
    logic [2:0] id_funct3;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm_i, id_imm_s;
    assign id_opcode = if_id_q.insn[6:0];
    assign id_rd     = if_id_q.insn[11:7];
    assign id_funct3 = if_id_q.insn[14:12];
    assign id_rs1    = if_id_q.insn[19:15];
    assign id_rs2    = if_id_q.insn[24:20];
    assign id_funct7 = if_id_q.insn[31:25];
    assign id_imm_i  = {{20{if_id_q.insn[31]}}, if_id_q.insn[31:20]};
    assign id_imm_s  = {{20{if_id_q.insn[31]}}, if_id_q.insn[31:25], if_id_q.insn[11:7]};

    pp_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .ra1_i  (id_rs1),
        .ra2_i  (id_rs2),
        .rd1_o  (rf_rd1),
        .rd2_o  (rf_rd2),
        .we_i   (mem_wb_q.reg_we),
        .wa_i   (mem_wb_q.rd),
        .wd_i   (mem_wb_q.wb_val),
        .regs_o (rf_regs)
    );

    // Decode: unsupported encodings fall through with all write enables low.
    always_comb begin
        id_ex_d         = '0;
        id_ex_d.alu_op  = ALU_ADD;
        id_ex_d.rs1_val = rf_rd1;
        id_ex_d.rs2_val = rf_rd2;
        id_ex_d.rd      = id_rd;
        case (id_opcode)
            OP_RTYPE: begin
                if (id_funct3 == F3_ADD_SUB && id_funct7 == F7_BASE) begin
                    id_ex_d.reg_we = 1'b1;
                    id_ex_d.alu_op = ALU_ADD;
                end else if (id_funct3 == F3_ADD_SUB && id_funct7 == F7_SUB) begin
                    id_ex_d.reg_we = 1'b1;
                    id_ex_d.alu_op = ALU_SUB;
                end else if (id_funct3 == F3_AND && id_funct7 == F7_BASE) begin
                    id_ex_d.reg_we = 1'b1;
                    id_ex_d.alu_op = ALU_AND;
                end else if (id_funct3 == F3_OR && id_funct7 == F7_BASE) begin
                    id_ex_d.reg_we = 1'b1;
                    id_ex_d.alu_op = ALU_OR;
                end
            end
            OP_IMM: begin
                if (id_funct3 == F3_ADD_SUB) begin
                    id_ex_d.reg_we  = 1'b1;
                    id_ex_d.use_imm = 1'b1;
                    id_ex_d.imm     = id_imm_i;
                end
            end
            OP_LOAD: begin
                if (id_funct3 == F3_WORD) begin
                    id_ex_d.reg_we  = 1'b1;
                    id_ex_d.mem_re  = 1'b1;
                    id_ex_d.use_imm = 1'b1;
                    id_ex_d.imm     = id_imm_i;
                end
            end
            OP_STORE: begin
                if (id_funct3 == F3_WORD) begin
                    id_ex_d.mem_we  = 1'b1;
                    id_ex_d.use_imm = 1'b1;
                    id_ex_d.imm     = id_imm_s;
                end
            end
            default: ;
        endcase
    end

    // EX: ALU, which also forms load/store addresses.
    logic [31:0] ex_op_b;
    assign ex_op_b = id_ex_q.use_imm ? id_ex_q.imm : id_ex_q.rs2_val;

    // Execute the selected ALU operation.
    always_comb begin
        ex_mem_d           = '0;
        ex_mem_d.store_val = id_ex_q.rs2_val;
        ex_mem_d.rd        = id_ex_q.rd;
        ex_mem_d.reg_we    = id_ex_q.reg_we;
        ex_mem_d.mem_re    = id_ex_q.mem_re;
        ex_mem_d.mem_we    = id_ex_q.mem_we;
        case (id_ex_q.alu_op)
            ALU_SUB: ex_mem_d.alu_res = id_ex_q.rs1_val - ex_op_b;
            ALU_AND: ex_mem_d.alu_res = id_ex_q.rs1_val & ex_op_b;
            ALU_OR:  ex_mem_d.alu_res = id_ex_q.rs1_val | ex_op_b;
            default: ex_mem_d.alu_res = id_ex_q.rs1_val + ex_op_b;
        endcase
    end

    // MEM: combinational read, low address bits ignored.
    logic [31:0] mem_rdata;
    assign mem_rdata = dmem[ex_mem_q.alu_res[7:2]];

    // Select load data or ALU result for writeback.
    always_comb begin
        mem_wb_d        = '0;
        mem_wb_d.wb_val = ex_mem_q.mem_re ? mem_rdata : ex_mem_q.alu_res;
        mem_wb_d.rd     = ex_mem_q.rd;
        mem_wb_d.reg_we = ex_mem_q.reg_we;
    end

    // PC and pipeline registers; reset empties the pipeline with bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= '0;
            if_id_q.insn  <= NOP_INSN;
            id_ex_q       <= '0;
            ex_mem_q      <= '0;
            mem_wb_q      <= '0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // Instruction memory reloads the built-in program during reset and holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                imem[i] <= program_word(6'(i));
            end
        end
    end

    // Data memory: cleared in reset, written by stores in MEM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                dmem[i] <= '0;
            end
        end else if (ex_mem_q.mem_we) begin
            dmem[ex_mem_q.alu_res[7:2]] <= ex_mem_q.store_val;
        end
    end

    assign debug_reg_x0     = rf_regs[0];
    assign debug_reg_x1     = rf_regs[1];
    assign debug_reg_x2     = rf_regs[2];
    assign debug_reg_x3     = rf_regs[3];
    assign debug_reg_x4     = rf_regs[4];
    assign debug_reg_x5     = rf_regs[5];
    assign debug_reg_x6     = rf_regs[6];
    assign debug_reg_x7     = rf_regs[7];
    assign debug_reg_x10    = rf_regs[10];
    assign debug_data_mem_0 = dmem[0];

    // Registers not brought out to debug ports.
    logic unused_dbg;
    assign unused_dbg = ^{rf_regs[31:11], rf_regs[9:8]};

endmodule

// File: tb/tb_pipelined_processor.sv
// Bench for pipelined_processor: instruction-level timing model plus directed literal checks.
// Covers reset, built-in program, write latency, x0 handling, bypass choice, mid-run reset.
// Honors RF_BYPASS_EN for the expected read-during-write result.
module tb_pipelined_processor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] debug_reg_x0, debug_reg_x1, debug_reg_x2, debug_reg_x3, debug_reg_x4;
    logic [31:0] debug_reg_x5, debug_reg_x6, debug_reg_x7, debug_reg_x10, debug_data_mem_0;

    always #5 clk = ~clk;

    pipelined_processor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .debug_reg_x0     (debug_reg_x0),
        .debug_reg_x1     (debug_reg_x1),
        .debug_reg_x2     (debug_reg_x2),
        .debug_reg_x3     (debug_reg_x3),
        .debug_reg_x4     (debug_reg_x4),
        .debug_reg_x5     (debug_reg_x5),
        .debug_reg_x6     (debug_reg_x6),
        .debug_reg_x7     (debug_reg_x7),
        .debug_reg_x10    (debug_reg_x10),
        .debug_data_mem_0 (debug_data_mem_0)
    );

`ifdef RF_BYPASS_EN
    localparam logic [31:0] EXP_HAZ_X2 = 32'd4;
`else
    localparam logic [31:0] EXP_HAZ_X2 = 32'd1;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Observed debug values: x0..x7, x10, dmem[0].
    logic [31:0] dbg [10];
    always_comb begin
        dbg[0] = debug_reg_x0;  dbg[1] = debug_reg_x1;  dbg[2] = debug_reg_x2;
        dbg[3] = debug_reg_x3;  dbg[4] = debug_reg_x4;  dbg[5] = debug_reg_x5;
        dbg[6] = debug_reg_x6;  dbg[7] = debug_reg_x7;  dbg[8] = debug_reg_x10;
        dbg[9] = debug_data_mem_0;
    end

    logic [31:0] prog [15] = '{32'h00500093, 32'h00A00113, 32'h00000013, 32'h00000013,
                               32'h00000013, 32'h002081B3, 32'h40110233, 32'h0020F2B3,
                               32'h0020E333, 32'h00302023, 32'h00002383, 32'h00000013,
                               32'h00000013, 32'h00000013, 32'h00138513};
    logic [31:0] final_exp [10] = '{32'h0, 32'h5, 32'hA, 32'hF, 32'h5, 32'h0,
                                    32'hF, 32'hF, 32'h10, 32'hF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    localparam int K_NOP = 0, K_ADD = 1, K_SUB = 2, K_AND = 3, K_OR = 4,
                   K_ADDI = 5, K_LW = 6, K_SW = 7;

    logic [31:0] m_imem [64];
    logic [31:0] m_reg  [32];
    logic [31:0] m_dmem [64];
    logic [31:0] p_insn [8];
    logic [31:0] p_a    [8];
    logic [31:0] p_b    [8];
    logic [31:0] p_res  [8];
    int          m_n;

    function automatic int kind_of(input logic [31:0] ins);
        logic [6:0] op, f7;
        logic [2:0] f3;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) return K_ADD;
        if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) return K_SUB;
        if (op == 7'h33 && f3 == 3'd7 && f7 == 7'h00) return K_AND;
        if (op == 7'h33 && f3 == 3'd6 && f7 == 7'h00) return K_OR;
        if (op == 7'h13 && f3 == 3'd0) return K_ADDI;
        if (op == 7'h03 && f3 == 3'd2) return K_LW;
        if (op == 7'h23 && f3 == 3'd2) return K_SW;
        return K_NOP;
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:25], ins[11:7]};
    endfunction

    // Register read at ID; an instruction in WB on the same edge may be bypassed.
    function automatic logic [31:0] id_read(input logic [4:0] r);
        int w;
        int kw;
        w = m_n - 5;
        if (r == 5'd0) return 32'd0;
        if (w >= 0) begin
            kw = kind_of(p_insn[w % 8]);
            if (kw >= K_ADD && kw <= K_LW && p_insn[w % 8][11:7] == r) begin
`ifdef RF_BYPASS_EN
                return p_res[w % 8];
`endif
            end
        end
        return m_reg[r];
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        for (int i = 0; i < 64; i++) begin
            m_dmem[i] = '0;
            m_imem[i] = (i < 15) ? prog[i] : 32'h00000013;
        end
    endtask

    // One rising edge: instruction k is read at edge k+2, executes/accesses memory
    // at edge k+4, writes its register at edge k+5; edge n fetches word n-1.
    task automatic model_step();
        int k, s, kd;
        logic [31:0] ins, addr;
        m_n++;
        k = m_n - 2;
        if (k >= 0) begin
            s = k % 8; ins = p_insn[s];
            p_a[s] = id_read(ins[19:15]);
            p_b[s] = id_read(ins[24:20]);
        end
        k = m_n - 4;
        if (k >= 0) begin
            s = k % 8; ins = p_insn[s]; kd = kind_of(ins);
            case (kd)
                K_ADD:  p_res[s] = p_a[s] + p_b[s];
                K_SUB:  p_res[s] = p_a[s] - p_b[s];
                K_AND:  p_res[s] = p_a[s] & p_b[s];
                K_OR:   p_res[s] = p_a[s] | p_b[s];
                K_ADDI: p_res[s] = p_a[s] + imm_i(ins);
                K_LW: begin
                    addr = p_a[s] + imm_i(ins);
                    p_res[s] = m_dmem[addr[7:2]];
                end
                K_SW: begin
                    addr = p_a[s] + imm_s(ins);
                    m_dmem[addr[7:2]] = p_b[s];
                end
                default: p_res[s] = '0;
            endcase
        end
        k = m_n - 5;
        if (k >= 0) begin
            s = k % 8; ins = p_insn[s]; kd = kind_of(ins);
            if (kd >= K_ADD && kd <= K_LW && ins[11:7] != 5'd0)
                m_reg[ins[11:7]] = p_res[s];
        end
        k = m_n - 1;
        p_insn[k % 8] = m_imem[k % 64];
    endtask

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) model_reset();
        else       model_step();
    end

    // Compare every debug output against the model each cycle out of reset.
    always @(negedge clk) begin
        if (chk_en && !rst_n) begin
            for (int i = 0; i < 8; i++) check($sformatf("cyc_x%0d", i), dbg[i], m_reg[i]);
            check("cyc_x10", dbg[8], m_reg[10]);
            check("cyc_dmem0", dbg[9], m_dmem[0]);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic pulse_reset();
        rst_n = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b0;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
        #2;
    endtask

    task automatic check_final(input string tag);
        for (int i = 0; i < 10; i++) check($sformatf("%s_%0d", tag, i), dbg[i], final_exp[i]);
    endtask

    task automatic preload(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 64; i++) begin
            dut.imem[i] <= (i < 4) ? w[i] : 32'h00000013;
            m_imem[i]    = (i < 4) ? w[i] : 32'h00000013;
        end
    endtask

    initial begin
        // Reset held two cycles.
        run(2);
        check("rst_pc", dut.pc_q, 32'd0);
        for (int i = 0; i < 10; i++) check($sformatf("rst_dbg%0d", i), dbg[i], 32'd0);

        rst_n  = 1'b0;
        chk_en = 1'b1;

        // addi x1 commits on edge 5, addi x2 on edge 6.
        run(4);
        check("lat_x1_e4", debug_reg_x1, 32'd0);
        run(1);
        check("lat_x1_e5", debug_reg_x1, 32'd5);
        check("lat_x2_e5", debug_reg_x2, 32'd0);
        run(1);
        check("lat_x2_e6", debug_reg_x2, 32'hA);
        run(34);
        check_final("prog");

        // Restart, run 8 cycles, reset for one cycle mid-program, then run to completion.
        pulse_reset();
        run(8);
        check("mid_x1_before", debug_reg_x1, 32'd5);
        pulse_reset();
        check("mid_x1_cleared", debug_reg_x1, 32'd0);
        check("mid_x2_cleared", debug_reg_x2, 32'd0);
        run(40);
        check_final("rerun");

        // Writes to x0 are dropped.
        pulse_reset();
        preload(32'h00700013, 32'h00000093, 32'h00000013, 32'h00000013);
        run(12);
        check("x0_stays0", debug_reg_x0, 32'd0);
        check("x1_from_x0", debug_reg_x1, 32'd0);

        // Read of x1 in the same cycle as its writeback.
        pulse_reset();
        preload(32'h00300093, 32'h00000013, 32'h00000013, 32'h00108113);
        run(12);
        check("haz_x1", debug_reg_x1, 32'd3);
        check("haz_x2", debug_reg_x2, EXP_HAZ_X2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
